mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single-ported main data memory, shared between the instruction-fetch requester and the load/store requester of the multi-cycle processor. It accepts one request at a time, issues it to the memory as a one-cycle strobe, waits out the memory's fixed read latency and returns data with a one-cycle acknowledge. It sits between the processor state machine and the memory array, replacing direct combinational array indexing.

---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single-ported data memory shared by instruction fetch and load/store.
// Optional macro MEM_ARB_RR_EN: round-robin on simultaneous requests (default: data port always wins).

module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic       OWN_FETCH = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [3:0] LAT_LOAD  = 4'(MEM_LAT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          busy_q, busy_d;
    logic          finish;
    logic          capture;
    logic          pick_data;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == S_ISSUE) begin
            last_d = owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_FETCH;
        end else begin
            last_q <= last_d;
        end
    end

    // On a tie the port that did not own the previous transaction wins.
    assign pick_data = (d_req && f_req) ? (last_q == OWN_FETCH) : d_req;
`else
    assign pick_data = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        m_en_d    = 1'b0;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        finish    = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (f_req || d_req) begin
                    state_d = S_ISSUE;
                    m_en_d  = 1'b1;
                    if (pick_data) begin
                        owner_d   = OWN_DATA;
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                    end else begin
                        owner_d   = OWN_FETCH;
                        m_we_d    = 1'b0;
                        m_addr_d  = f_addr;
                        m_wdata_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (m_we_q) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            S_WAIT: begin
                // Terminal count is "1 or less" so the counter can never wrap.
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_FETCH;
            cnt_q     <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            busy_q    <= busy_d;
        end
    end

    // Per-port ack/rdata registers: index 0 is fetch, index 1 is data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            logic          ack_q, ack_d;
            logic [DW-1:0] rdata_q, rdata_d;

            always_comb begin
                ack_d   = finish && (owner_q == PORT_ID);
                rdata_d = rdata_q;
                if (capture && (owner_q == PORT_ID)) begin
                    rdata_d = m_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    ack_q   <= ack_d;
                    rdata_q <= rdata_d;
                end
            end
        end
    endgenerate

    assign f_ack   = g_port[0].ack_q;
    assign f_rdata = g_port[0].rdata_q;
    assign d_ack   = g_port[1].ack_q;
    assign d_rdata = g_port[1].rdata_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: transaction-level timing/priority model plus latency-1/15 instances.
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata, m_rdata;
    logic          f_ack, d_ack, m_en, m_we, busy;
    logic [DW-1:0] f_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    // Extra instances exercising the latency extremes (index 0: MEM_LAT=1, index 1: MEM_LAT=15).
    logic [1:0]    x_f_req, x_f_ack, x_d_ack, x_m_en, x_m_we, x_busy;
    logic [AW-1:0] x_f_addr;
    logic [AW-1:0] x_m_addr [2];
    logic [DW-1:0] x_f_rdata [2];
    logic [DW-1:0] x_d_rdata [2];
    logic [DW-1:0] x_m_wdata [2];
    logic [DW-1:0] x_m_rdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lat
            mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(gi == 0 ? 1 : 15)) u_x (
                .clk(clk), .reset(reset),
                .f_req(x_f_req[gi]), .f_addr(x_f_addr), .f_ack(x_f_ack[gi]), .f_rdata(x_f_rdata[gi]),
                .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
                .d_ack(x_d_ack[gi]), .d_rdata(x_d_rdata[gi]),
                .m_en(x_m_en[gi]), .m_we(x_m_we[gi]), .m_addr(x_m_addr[gi]), .m_wdata(x_m_wdata[gi]),
                .m_rdata(x_m_rdata[gi]), .busy(x_busy[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Memories: env_mem answers the DUT, ref_mem is the model's own view.
    logic [DW-1:0] env_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] pd [64];
    bit            pv [64];

    function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
        return env_mem.exists(a) ? env_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // Transaction-level model state.
    bit            has_txn, t_own, t_we, cmd_zero, last_own;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rd, e_frd, e_drd;
    int            t_s, t_a, free_c;

    // Requester state.
    bit f_out, d_out, f_hold, d_hold;

    typedef struct {
        int            at;
        int            kind;   // 0 fetch, 1 data, 2 reset
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            hold;
    } scr_t;
    scr_t script [$];

    task automatic start_fetch(input logic [AW-1:0] a, input bit h);
        f_out  = 1'b1;
        f_req  = 1'b1;
        f_addr = a;
        f_hold = h;
    endtask

    task automatic start_data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit h);
        d_out   = 1'b1;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_hold  = h;
    endtask

    task automatic step(input bit rnd);
        bit exp_en, exp_busy, exp_fack, exp_dack, rst, f_done, d_done, own;
        @(negedge clk);
        // Expected outputs for this cycle from the current transaction's timeline.
        exp_en   = has_txn && (cyc == t_s + 1);
        exp_busy = has_txn && (cyc >= t_s + 1) && (cyc <= t_a);
        exp_fack = has_txn && !t_own && (cyc == t_a);
        exp_dack = has_txn && t_own && (cyc == t_a);
        if (has_txn && cyc == t_a && !t_we) begin
            if (t_own) e_drd = t_rd;
            else       e_frd = t_rd;
        end
        check_val("f_ack", f_ack, exp_fack);
        check_val("d_ack", d_ack, exp_dack);
        check_val("busy", busy, exp_busy);
        check_val("m_en", m_en, exp_en);
        check_val("f_rdata", f_rdata, e_frd);
        check_val("d_rdata", d_rdata, e_drd);
        if (exp_en) begin
            cmd_zero = 1'b0;
            check_val("m_addr", m_addr, t_addr);
            check_val("m_we", m_we, t_we);
            if (t_we) check_val("m_wdata", m_wdata, t_wdata);
        end else if (cmd_zero) begin
            check_val("m_addr_rst", m_addr, '0);
            check_val("m_we_rst", m_we, '0);
            check_val("m_wdata_rst", m_wdata, '0);
        end
        if (has_txn && cyc == t_a) begin
            $display("txn %s %s addr=%h data=%h sampled=%0d ack=%0d", t_own ? "D" : "F",
                     t_we ? "ST" : "LD", t_addr, t_we ? t_wdata : t_rd, t_s, t_a);
            has_txn = 1'b0;
            free_c  = cyc + 1;
        end

        // Memory environment: fixed read latency, garbage on m_rdata in all other cycles.
        if (m_en) begin
            if (m_we) begin
                env_mem[m_addr] = m_wdata;
            end else begin
                pv[(cyc + LAT) % 64] = 1'b1;
                pd[(cyc + LAT) % 64] = env_rd(m_addr);
            end
        end
        m_rdata = pv[cyc % 64] ? pd[cyc % 64] : DW'($urandom);
        pv[cyc % 64] = 1'b0;

        // Requesters react to acks.
        f_done = 1'b0;
        d_done = 1'b0;
        if (f_ack && f_out) begin
            f_done = 1'b1;
            if (f_hold) f_hold = 1'b0;
            else begin f_out = 1'b0; f_req = 1'b0; end
        end
        if (d_ack && d_out) begin
            d_done = 1'b1;
            if (d_hold) d_hold = 1'b0;
            else begin d_out = 1'b0; d_req = 1'b0; end
        end

        rst = rnd && ($urandom_range(0, 399) == 0);
        foreach (script[i]) if (script[i].at == cyc && script[i].kind == 2) rst = 1'b1;
        reset = rst;
        if (rst) begin
            f_req = 1'b0; d_req = 1'b0;
            f_out = 1'b0; d_out = 1'b0; f_hold = 1'b0; d_hold = 1'b0;
        end else begin
            foreach (script[i]) begin
                if (script[i].at == cyc && script[i].kind == 0 && !f_out)
                    start_fetch(script[i].addr, script[i].hold);
                if (script[i].at == cyc && script[i].kind == 1 && !d_out)
                    start_data(script[i].we, script[i].addr, script[i].wdata, script[i].hold);
            end
            if (rnd && !f_out && !f_done && $urandom_range(0, 2) == 0)
                start_fetch(AW'($urandom_range(0, 31)), $urandom_range(0, 9) == 0);
            if (rnd && !d_out && !d_done && $urandom_range(0, 2) == 0)
                start_data($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom),
                           $urandom_range(0, 9) == 0);
        end

        // Model: reset abandons everything; otherwise an idle arbiter accepts one request.
        if (rst) begin
            has_txn  = 1'b0;
            e_frd    = '0;
            e_drd    = '0;
            cmd_zero = 1'b1;
            last_own = 1'b0;
            free_c   = cyc + 1;
        end else if (!has_txn && cyc >= free_c && (f_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
            own = (f_req && d_req) ? !last_own : d_req;
`else
            own = d_req;
`endif
            t_own   = own;
            t_we    = own ? d_we : 1'b0;
            t_addr  = own ? d_addr : f_addr;
            t_wdata = d_wdata;
            t_s     = cyc;
            t_a     = cyc + (t_we ? 2 : LAT + 2);
            t_rd    = ref_rd(t_addr);
            if (t_we) ref_mem[t_addr] = t_wdata;
            last_own = own;
            has_txn  = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        int ack_c [2];
        int en_c [2];
        int en_n [2];
        int lat;

        reset = 1'b1;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        x_f_req = 2'b00; x_f_addr = '0;
        x_m_rdata[0] = '0; x_m_rdata[1] = '0;
        foreach (pv[i]) pv[i] = 1'b0;
        env_mem[AW'(16'h0010)] = 32'hDEADBEEF;
        ref_mem[AW'(16'h0010)] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Latency extremes: one fetch read on each extra instance, sampled in cycle 0.
        for (int i = 0; i < 2; i++) begin
            ack_c[i] = -1; en_c[i] = -1; en_n[i] = 0;
        end
        x_f_addr = AW'(16'h0033);
        x_f_req  = 2'b11;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                lat = (i == 0) ? 1 : 15;
                if (x_m_en[i]) begin
                    en_n[i]++;
                    en_c[i] = k;
                    check_val($sformatf("x%0d_m_addr", i), x_m_addr[i], 64'h0033);
                end
                if (x_f_ack[i] && ack_c[i] < 0) begin
                    ack_c[i] = k;
                    check_val($sformatf("x%0d_f_rdata", i), x_f_rdata[i], DW'(32'hC0DE0000 + i));
                    x_f_req[i] = 1'b0;
                end
                check_val($sformatf("x%0d_d_ack", i), x_d_ack[i], 0);
                x_m_rdata[i] = (en_c[i] > 0 && k == en_c[i] + lat) ? DW'(32'hC0DE0000 + i) : DW'($urandom);
            end
        end
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 15;
            check_val($sformatf("x%0d_ack_cycle", i), ack_c[i], lat + 2);
            check_val($sformatf("x%0d_m_en_count", i), en_n[i], 1);
            check_val($sformatf("x%0d_m_en_cycle", i), en_c[i], 1);
            check_val($sformatf("x%0d_busy_end", i), x_busy[i], 0);
        end

        // Directed scenarios on the main instance, then a long random phase.
        script.push_back('{0, 2, 1'b0, '0, '0, 1'b0});
        script.push_back('{1, 2, 1'b0, '0, '0, 1'b0});
        script.push_back('{2, 0, 1'b0, AW'(16'h0010), '0, 1'b0});
        script.push_back('{10, 1, 1'b1, AW'(16'h0020), 32'h12345678, 1'b0});
        script.push_back('{16, 1, 1'b0, AW'(16'h0020), '0, 1'b0});
        script.push_back('{25, 0, 1'b0, AW'(16'h0010), '0, 1'b0});
        script.push_back('{25, 1, 1'b0, AW'(16'h0020), '0, 1'b0});
        script.push_back('{45, 1, 1'b0, AW'(16'h0010), '0, 1'b1});
        script.push_back('{60, 1, 1'b0, AW'(16'h0020), '0, 1'b0});
        script.push_back('{62, 2, 1'b0, '0, '0, 1'b0});
        script.push_back('{70, 1, 1'b0, AW'(16'h0020), '0, 1'b0});

        has_txn = 1'b0; cmd_zero = 1'b1; last_own = 1'b0; free_c = 0;
        e_frd = '0; e_drd = '0;
        f_out = 1'b0; d_out = 1'b0; f_hold = 1'b0; d_hold = 1'b0;
        cyc = 0;
        repeat (90) step(1'b0);
        repeat (3000) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
